// File: rtl/i2c_target.sv
// I2C target protocol engine for the PID gain register file.
// Turns SCL/SDA bus traffic into register pointer updates, single-cycle
// write strobes and zero-padded read bytes. SDA is open-drain: sda_oe=1
// pulls the line low.
module i2c_target #(
  parameter logic [6:0] DEV_ADDR = 7'h42,
  parameter int         DATA_W   = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              scl,
  input  logic              sda_in,
  output logic              sda_oe,
  output logic [7:0]        reg_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              wr_en,
  input  logic [DATA_W-1:0] read_value,
  output logic              busy
);

  typedef enum logic [3:0] {
    S_IDLE, S_DEV_ADDR, S_ACK_DEV, S_REG_PTR, S_ACK_PTR,
    S_WR_DATA, S_ACK_WR, S_RD_DATA, S_RD_ACK, S_IGNORE
  } state_t;

  state_t              state_reg, state_next;
  logic [2:0]          scl_sync_reg, sda_sync_reg;
  logic [3:0]          bit_cnt_reg, bit_cnt_next;
  logic [7:0]          shift_reg, shift_next;
  logic                sda_oe_reg, sda_oe_next;
  logic [7:0]          reg_addr_reg, reg_addr_next;
  logic [DATA_W-1:0]   wr_data_reg, wr_data_next;
  logic                wr_en_reg, wr_en_next;
  logic                busy_reg, busy_next;
  logic                inc_reg, inc_next;

  // Bus events from the synchronized pins; index 1 is current, 2 is previous.
  logic       scl_high, scl_rise, scl_fall, start_det, stop_det, sda_bit;
  logic [7:0] rd_byte;

  assign scl_high  = scl_sync_reg[1] & scl_sync_reg[2];
  assign scl_rise  = scl_sync_reg[1] & ~scl_sync_reg[2];
  assign scl_fall  = ~scl_sync_reg[1] & scl_sync_reg[2];
  assign start_det = scl_high & sda_sync_reg[2] & ~sda_sync_reg[1];
  assign stop_det  = scl_high & ~sda_sync_reg[2] & sda_sync_reg[1];
  assign sda_bit   = sda_sync_reg[1];
  assign rd_byte   = 8'(read_value);

  assign sda_oe   = sda_oe_reg;
  assign reg_addr = reg_addr_reg;
  assign wr_data  = wr_data_reg;
  assign wr_en    = wr_en_reg;
  assign busy     = busy_reg;

  // Pin synchronizers (2 flops + 1 for edge detection); idle bus is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync_reg <= 3'b111;
      sda_sync_reg <= 3'b111;
    end else begin
      scl_sync_reg <= {scl_sync_reg[1:0], scl};
      sda_sync_reg <= {sda_sync_reg[1:0], sda_in};
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= S_IDLE;
      bit_cnt_reg  <= 4'd0;
      shift_reg    <= 8'd0;
      sda_oe_reg   <= 1'b0;
      reg_addr_reg <= 8'd0;
      wr_data_reg  <= '0;
      wr_en_reg    <= 1'b0;
      busy_reg     <= 1'b0;
      inc_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      bit_cnt_reg  <= bit_cnt_next;
      shift_reg    <= shift_next;
      sda_oe_reg   <= sda_oe_next;
      reg_addr_reg <= reg_addr_next;
      wr_data_reg  <= wr_data_next;
      wr_en_reg    <= wr_en_next;
      busy_reg     <= busy_next;
      inc_reg      <= inc_next;
    end
  end

  // Next-state logic: STOP/disable first, then START, then per-state bit handling.
  always_comb begin
    state_next    = state_reg;
    bit_cnt_next  = bit_cnt_reg;
    shift_next    = shift_reg;
    sda_oe_next   = sda_oe_reg;
    reg_addr_next = inc_reg ? reg_addr_reg + 8'd1 : reg_addr_reg;
    wr_data_next  = wr_data_reg;
    wr_en_next    = 1'b0;
    busy_next     = busy_reg;
    inc_next      = 1'b0;

    if (!ena || stop_det) begin
      state_next   = S_IDLE;
      sda_oe_next  = 1'b0;
      busy_next    = 1'b0;
      bit_cnt_next = 4'd0;
    end else if (start_det) begin
      state_next   = S_DEV_ADDR;
      bit_cnt_next = 4'd0;
      sda_oe_next  = 1'b0;
    end else begin
      case (state_reg)
        S_DEV_ADDR: begin
          if (scl_rise && bit_cnt_reg < 4'd8) begin
            shift_next   = {shift_reg[6:0], sda_bit};
            bit_cnt_next = bit_cnt_reg + 4'd1;
          end else if (scl_fall && bit_cnt_reg == 4'd8) begin
            if (shift_reg[7:1] == DEV_ADDR) begin
              sda_oe_next = 1'b1;
              busy_next   = 1'b1;
              state_next  = S_ACK_DEV;
            end else begin
              busy_next   = 1'b0;
              state_next  = S_IGNORE;
            end
          end
        end
        S_ACK_DEV: begin
          if (scl_fall) begin
            if (!shift_reg[0]) begin
              sda_oe_next  = 1'b0;
              bit_cnt_next = 4'd0;
              state_next   = S_REG_PTR;
            end else begin
              // First read byte: MSB goes out on the fall ending the ACK.
              shift_next   = rd_byte;
              sda_oe_next  = ~rd_byte[7];
              bit_cnt_next = 4'd1;
              state_next   = S_RD_DATA;
            end
          end
        end
        S_REG_PTR: begin
          if (scl_rise && bit_cnt_reg < 4'd8) begin
            shift_next   = {shift_reg[6:0], sda_bit};
            bit_cnt_next = bit_cnt_reg + 4'd1;
            if (bit_cnt_reg == 4'd7) reg_addr_next = {shift_reg[6:0], sda_bit};
          end else if (scl_fall && bit_cnt_reg == 4'd8) begin
            sda_oe_next = 1'b1;
            state_next  = S_ACK_PTR;
          end
        end
        S_ACK_PTR, S_ACK_WR: begin
          if (scl_fall) begin
            sda_oe_next  = 1'b0;
            bit_cnt_next = 4'd0;
            state_next   = S_WR_DATA;
          end
        end
        S_WR_DATA: begin
          if (scl_rise && bit_cnt_reg < 4'd8) begin
            shift_next   = {shift_reg[6:0], sda_bit};
            bit_cnt_next = bit_cnt_reg + 4'd1;
          end else if (scl_fall && bit_cnt_reg == 4'd8) begin
            // Strobe now; pointer advances one clk later via inc_reg.
            wr_data_next = shift_reg[DATA_W-1:0];
            wr_en_next   = 1'b1;
            inc_next     = 1'b1;
            sda_oe_next  = 1'b1;
            state_next   = S_ACK_WR;
          end
        end
        S_RD_DATA: begin
          if (scl_fall) begin
            if (bit_cnt_reg < 4'd8) begin
              shift_next   = {shift_reg[6:0], 1'b0};
              sda_oe_next  = ~shift_reg[6];
              bit_cnt_next = bit_cnt_reg + 4'd1;
            end else begin
              sda_oe_next  = 1'b0;
              bit_cnt_next = 4'd0;
              state_next   = S_RD_ACK;
            end
          end
        end
        S_RD_ACK: begin
          // bit_cnt 0: waiting for master's ACK bit; 1: ACK seen, reload on fall.
          if (scl_rise && bit_cnt_reg == 4'd0) begin
            reg_addr_next = reg_addr_reg + 8'd1;
            if (!sda_bit) begin
              bit_cnt_next = 4'd1;
            end else begin
              sda_oe_next = 1'b0;
              busy_next   = 1'b0;
              state_next  = S_IGNORE;
            end
          end else if (scl_fall && bit_cnt_reg == 4'd1) begin
            shift_next   = rd_byte;
            sda_oe_next  = ~rd_byte[7];
            state_next   = S_RD_DATA;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_target.sv
// Self-checking bench for i2c_target: a bit-banged I2C master, a stand-in
// register bank, and a transaction-level model (pointer + memory image +
// expected-write queue) checked against the DUT.
module tb_i2c_target;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b0;
  logic       scl = 1'b1;
  logic       sda_m = 1'b1;
  logic       sda_line;
  logic       sda_oe;
  logic [7:0] reg_addr;
  logic [5:0] wr_data;
  logic       wr_en;
  logic [5:0] read_value;
  logic       busy;

  int errors = 0;
  int checks = 0;

  // Model state
  logic [5:0]  mdl_mem [256];
  logic [7:0]  mdl_ptr = 8'd0;
  logic [13:0] exp_q [$];
  logic        quiet = 1'b0;
  logic [7:0]  wdata [8];
  logic [7:0]  rdata [8];
  int          bank_seed;

  // Bench-side register bank
  logic [5:0] bank [256];
  logic       bank_ready = 1'b0;

  assign sda_line = sda_m & ~sda_oe;

  always #5 clk = ~clk;

  i2c_target #(.DEV_ADDR(7'h42), .DATA_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .scl(scl), .sda_in(sda_line),
    .sda_oe(sda_oe), .reg_addr(reg_addr), .wr_data(wr_data), .wr_en(wr_en),
    .read_value(read_value), .busy(busy)
  );

  function automatic logic [5:0] bank_fn(input int i);
    return 6'((i * 37 + bank_seed) ^ (i >> 3));
  endfunction

  always @(posedge clk) begin
    if (!bank_ready) begin
      for (int i = 0; i < 256; i++) bank[i] <= bank_fn(i);
      bank_ready <= 1'b1;
    end else if (wr_en) begin
      bank[reg_addr] <= wr_data;
    end
    read_value <= bank[reg_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Per-cycle compare: every strobe must match the next expected write;
  // nothing may drive SDA or raise busy while the model says the target is quiet.
  always @(negedge clk) begin
    if (rst_n) begin
      if (wr_en) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_wr_en", {31'b0, wr_en}, 32'd0);
        end else begin
          chk("wr_addr", {24'b0, reg_addr}, {24'b0, exp_q[0][13:6]});
          chk("wr_data", {26'b0, wr_data}, {26'b0, exp_q[0][5:0]});
          void'(exp_q.pop_front());
        end
      end
      if (quiet) begin
        chk("quiet_sda_oe", {31'b0, sda_oe}, 32'd0);
        chk("quiet_busy", {31'b0, busy}, 32'd0);
      end
    end
  end

  task automatic q();
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; q(); scl = 1'b1; q(); sda_m = 1'b0; q(); scl = 1'b0; q();
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; q(); scl = 1'b1; q(); sda_m = 1'b1; q(); q();
  endtask

  task automatic send_bit(input logic b);
    sda_m = b; q(); scl = 1'b1; q(); q(); scl = 1'b0; q();
  endtask

  task automatic recv_bit(output logic b);
    sda_m = 1'b1; q(); scl = 1'b1; q(); b = sda_line; q(); scl = 1'b0; q();
  endtask

  task automatic send_byte(input logic [7:0] v, input logic exp_ack, input string name);
    logic a;
    for (int i = 7; i >= 0; i--) send_bit(v[i]);
    recv_bit(a);
    chk(name, {31'b0, a}, {31'b0, ~exp_ack});
  endtask

  task automatic recv_byte(output logic [7:0] v);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      recv_bit(b);
      v[i] = b;
    end
  endtask

  task automatic do_write(input logic [7:0] ptr, input int n);
    $display("txn write ptr=%02h bytes=%0d", ptr, n);
    i2c_start();
    send_byte(8'h84, 1'b1, "dev_ack_w");
    chk("busy_on_w", {31'b0, busy}, 32'd1);
    send_byte(ptr, 1'b1, "ptr_ack");
    mdl_ptr = ptr;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({mdl_ptr, wdata[i][5:0]});
      mdl_mem[mdl_ptr] = wdata[i][5:0];
      mdl_ptr = mdl_ptr + 8'd1;
      send_byte(wdata[i], 1'b1, "data_ack");
    end
    i2c_stop();
    chk("ptr_after_w", {24'b0, reg_addr}, {24'b0, mdl_ptr});
    chk("busy_off_w", {31'b0, busy}, 32'd0);
  endtask

  task automatic do_read(input logic set_ptr, input logic [7:0] ptr, input int n);
    logic [7:0] v;
    $display("txn read set_ptr=%0d ptr=%02h bytes=%0d", set_ptr, set_ptr ? ptr : mdl_ptr, n);
    if (set_ptr) begin
      i2c_start();
      send_byte(8'h84, 1'b1, "dev_ack_p");
      send_byte(ptr, 1'b1, "ptr_ack_r");
      mdl_ptr = ptr;
    end
    i2c_start();
    send_byte(8'h85, 1'b1, "dev_ack_r");
    chk("busy_on_r", {31'b0, busy}, 32'd1);
    for (int i = 0; i < n; i++) begin
      recv_byte(v);
      rdata[i] = v;
      chk("rd_byte", {24'b0, v}, {26'b0, mdl_mem[mdl_ptr]});
      mdl_ptr = mdl_ptr + 8'd1;
      send_bit(i == n - 1);
    end
    i2c_stop();
    chk("ptr_after_r", {24'b0, reg_addr}, {24'b0, mdl_ptr});
    chk("busy_off_r", {31'b0, busy}, 32'd0);
  endtask

  task automatic do_mismatch(input logic [6:0] a, input logic rw, input int n);
    logic [7:0] v;
    $display("txn mismatch addr=%02h rw=%0d bytes=%0d", a, rw, n);
    quiet = 1'b1;
    i2c_start();
    send_byte({a, rw}, 1'b0, "mis_dev_nack");
    for (int i = 0; i < n; i++) begin
      if (rw) begin
        recv_byte(v);
        chk("mis_rd_idle", {24'b0, v}, 32'hFF);
        send_bit(1'b1);
      end else begin
        send_byte(wdata[i], 1'b0, "mis_data_nack");
      end
    end
    i2c_stop();
    quiet = 1'b0;
    chk("ptr_after_mis", {24'b0, reg_addr}, {24'b0, mdl_ptr});
  endtask

  initial begin
    logic       a;
    logic [7:0] v;
    logic [6:0] ra;

    bank_seed = int'($urandom_range(0, 63));
    for (int i = 0; i < 256; i++) mdl_mem[i] = bank_fn(i);

    repeat (3) @(posedge clk);
    #1;
    chk("rst_sda_oe", {31'b0, sda_oe}, 32'd0);
    chk("rst_reg_addr", {24'b0, reg_addr}, 32'd0);
    chk("rst_wr_data", {26'b0, wr_data}, 32'd0);
    chk("rst_wr_en", {31'b0, wr_en}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    rst_n = 1'b1;
    ena = 1'b1;
    q();

    // Write K_i
    wdata[0] = 8'h25;
    do_write(8'h01, 1);
    chk("t1_bank", {26'b0, bank[1]}, 32'h25);
    chk("t1_ptr", {24'b0, reg_addr}, 32'h02);

    // Burst write with masking
    wdata[0] = 8'hFF; wdata[1] = 8'h0A;
    do_write(8'h00, 2);
    chk("t2_bank0", {26'b0, bank[0]}, 32'h3F);
    chk("t2_bank1", {26'b0, bank[1]}, 32'h0A);
    chk("t2_ptr", {24'b0, reg_addr}, 32'h02);

    // Read K_d through repeated START
    wdata[0] = 8'h2C;
    do_write(8'h02, 1);
    do_read(1'b1, 8'h02, 1);
    chk("t3_byte", {24'b0, rdata[0]}, 32'h2C);
    chk("t3_ptr", {24'b0, reg_addr}, 32'h03);

    // Address mismatch
    wdata[0] = 8'h01; wdata[1] = 8'h15;
    do_mismatch(7'h50, 1'b0, 2);
    chk("t4_ptr", {24'b0, reg_addr}, 32'h03);

    // Pointer wrap and ACKed burst read
    wdata[0] = 8'h15; wdata[1] = 8'h33;
    do_write(8'hFF, 2);
    chk("t5_wrap_w", {24'b0, reg_addr}, 32'h01);
    do_write(8'hFF, 0);
    do_read(1'b0, 8'h00, 2);
    chk("t5_byte0", {24'b0, rdata[0]}, 32'h15);
    chk("t5_byte1", {24'b0, rdata[1]}, 32'h33);
    chk("t5_ptr", {24'b0, reg_addr}, 32'h01);

    // Async reset during the 4th data bit of a write
    $display("txn reset mid-byte");
    v = 8'hA5;
    i2c_start();
    send_byte(8'h84, 1'b1, "t6_dev_ack");
    send_byte(8'h01, 1'b1, "t6_ptr_ack");
    mdl_ptr = 8'h01;
    chk("t6_ptr_set", {24'b0, reg_addr}, 32'h01);
    for (int i = 7; i >= 5; i--) send_bit(v[i]);
    sda_m = v[4]; q(); scl = 1'b1; q();
    rst_n = 1'b0;
    quiet = 1'b1;
    #1;
    chk("t6_sda_oe", {31'b0, sda_oe}, 32'd0);
    chk("t6_wr_en", {31'b0, wr_en}, 32'd0);
    chk("t6_reg_addr", {24'b0, reg_addr}, 32'd0);
    q(); scl = 1'b0; q();
    rst_n = 1'b1;
    mdl_ptr = 8'h00;
    for (int i = 3; i >= 0; i--) send_bit(v[i]);
    recv_bit(a);
    chk("t6_no_ack", {31'b0, a}, 32'd1);
    i2c_stop();
    quiet = 1'b0;
    chk("t6_ptr_after", {24'b0, reg_addr}, 32'h00);

    // Randomized traffic
    for (int t = 0; t < 24; t++) begin
      int kind, n;
      kind = int'($urandom_range(0, 2));
      n = int'($urandom_range(1, 3));
      for (int i = 0; i < 8; i++) wdata[i] = 8'($urandom);
      if (kind == 0) begin
        do_write(8'($urandom), n);
      end else if (kind == 1) begin
        do_read(1'($urandom), 8'($urandom), n);
      end else begin
        ra = 7'($urandom);
        if (ra == 7'h42) ra = 7'h43;
        do_mismatch(ra, 1'($urandom), n);
      end
    end

    q();
    chk("pending_writes", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
